spike_rate_encoder: RTL and testbench
=====================================

// Module: spike_rate_encoder
// PURPOSE
//  Rate-codes an 8-bit stimulus sample into a deterministic spike train for the LIF neuron datapath.
//  It is the sending end of the synaptic-current path: it drives spikes toward the membrane-potential
//  decoder and returns a spike count per encoding window.
//  Encoding uses a first-order sigma-delta phase accumulator: spikes in a window = floor(val*W/2^DATA_W).
// PARAMETERS
//  DATA_W    8  width of input sample and phase accumulator
//  WIN_LOG2  8  log2 of window length; window W = 2^WIN_LOG2 cycles (WIN_LOG2 >= 1)
// PORTS
//  clk          in   1         single clock, all state on rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  in_data      in   DATA_W    stimulus value (intensity)
//  in_valid     in   1         in_data valid
//  in_ready     out  1         encoder can accept a sample (high only in IDLE)
//  en           in   1         advance enable; low freezes an active window
//  spike        out  1         registered spike pulse, one cycle wide per spike
//  busy         out  1         high in ENCODE or DONE
//  window_done  out  1         one-cycle pulse after the last spike slot of a window
//  spike_count  out  WIN_LOG2  spikes emitted in the last completed window
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; acc, slot counter, val, spike, window_done, spike_count all 0.
//   in_ready=1 once reset is released.
//  States: IDLE -> ENCODE -> DONE -> IDLE.
//  IDLE
//   - in_ready=1; in_valid&&in_ready at edge E0 latches val=in_data.
//   - Same edge: acc=0, slot n=0, running count=0; next state ENCODE.
//   - in_valid while not in IDLE is ignored; no sample is lost silently because in_ready=0.
//  ENCODE, edges E1..EW, only when en=1
//   - sum = {1'b0,acc} + val (DATA_W+1 bits); acc <= sum[DATA_W-1:0]; spike <= sum[DATA_W].
//   - Running count += sum[DATA_W]; n <= n+1.
//   - At the edge where n==W-1: spike_count <= final count (including this carry); next state DONE.
//  en=0 in ENCODE
//   - acc, n, count and state hold; spike <= 0.
//   - Window resumes exactly where it stopped; the spike total is unaffected by stalls.
//  DONE, one cycle, en ignored
//   - spike <= 0; window_done <= 1 for exactly one cycle; next state IDLE.
//  Timing and output hold
//   - Earliest next acceptance is at E(W+2).
//   - spike_count holds its value until the next window completes; it is not cleared at acceptance.
//  Arithmetic
//   - Acc wraps modulo 2^DATA_W; the carry is the spike.
//   - Total over W slots = floor(val*W/2^DATA_W) <= W-1, so spike_count never overflows.
//  Boundaries
//   - val=0: no spikes, spike_count=0.
//   - val=2^DATA_W-1 with W=2^DATA_W: 2^DATA_W-1 spikes.
//   - First spike in slot ceil(2^DATA_W/val).
//  Reset mid-window: aborts immediately; outputs take reset values; no window_done pulse.
//  busy = (state != IDLE); in_ready = (state == IDLE); both combinational from the state register.
// TESTING
//  T1 val=0, en=1: no spike in 256 slots; window_done one cycle after E256; spike_count=0.
//  T2 val=128, en=1: spikes after E2,E4,...,E256 (alternating); spike_count=128; in_ready returns after DONE.
//  T3 val=255: 255 spikes, the only missing slot is E1; spike_count=255. val=1: single spike after E256; spike_count=1.
//  T4 val=64, en low for 10 cycles at slot 37: spike low and frozen during the stall; 64 spikes total;
//     window_done delayed by exactly 10 cycles.
//  T5 in_valid held high with changing in_data during ENCODE: ignored; second sample accepted only
//     once in_ready=1 after DONE; its count is independent of the first window.
//  T6 rst_n low at slot 100 of val=200: spike, busy, window_done and spike_count go to 0 asynchronously;
//     in_ready=1 after release; a fresh val=200 window yields 200.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// Purpose : rate-codes an 8-bit stimulus sample into a deterministic spike train
//           using a first-order sigma-delta phase accumulator over a window of
//           W = 2^WIN_LOG2 slots; spikes per window = floor(val*W/2^DATA_W).
// Latency : sample accepted at E0, slot k spike visible after edge Ek, window_done
//           pulses after E(W+1); next sample can be accepted at E(W+2).
// Backpr. : in_ready is high only in IDLE; en=0 freezes an active window in place.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data/in_valid   stimulus sample handshake (accepted when in_ready)
//   in_ready           high only while IDLE
//   en                 advance enable for the encoding window
//   spike              registered one-cycle spike pulse
//   busy               high while ENCODE or DONE
//   window_done        one-cycle pulse after the last slot of a window
//   spike_count        spikes in the last completed window (held until the next)
module spike_rate_encoder #(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                en,
  output logic                spike,
  output logic                busy,
  output logic                window_done,
  output logic [WIN_LOG2-1:0] spike_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Slot index of the final slot in a window (W-1 is all ones).
  localparam logic [WIN_LOG2-1:0] LAST_SLOT = '1;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic [DATA_W-1:0]   val, val_nxt;
  logic [WIN_LOG2-1:0] slot, slot_nxt;
  logic [WIN_LOG2-1:0] run_cnt, run_cnt_nxt;
  logic [WIN_LOG2-1:0] spike_count_nxt;
  logic                spike_nxt;
  logic                window_done_nxt;

  // Phase accumulator step: the carry out of the DATA_W-bit add is the spike.
  logic [DATA_W:0]     sum;
  assign sum = {1'b0, acc} + {1'b0, val};

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      acc         <= '0;
      val         <= '0;
      slot        <= '0;
      run_cnt     <= '0;
      spike       <= 1'b0;
      window_done <= 1'b0;
      spike_count <= '0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      val         <= val_nxt;
      slot        <= slot_nxt;
      run_cnt     <= run_cnt_nxt;
      spike       <= spike_nxt;
      window_done <= window_done_nxt;
      spike_count <= spike_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    acc_nxt         = acc;
    val_nxt         = val;
    slot_nxt        = slot;
    run_cnt_nxt     = run_cnt;
    spike_count_nxt = spike_count;
    spike_nxt       = 1'b0;
    window_done_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          val_nxt     = in_data;
          acc_nxt     = '0;
          slot_nxt    = '0;
          run_cnt_nxt = '0;
          state_nxt   = S_ENCODE;
        end
      end

      S_ENCODE: begin
        // With en low everything holds and spike_nxt stays 0, so a stall
        // never changes the window's spike total.
        if (en) begin
          acc_nxt     = sum[DATA_W-1:0];
          spike_nxt   = sum[DATA_W];
          run_cnt_nxt = run_cnt + {{(WIN_LOG2-1){1'b0}}, sum[DATA_W]};
          slot_nxt    = slot + 1'b1;
          if (slot == LAST_SLOT) begin
            // Total is at most W-1, so it always fits in WIN_LOG2 bits.
            spike_count_nxt = run_cnt_nxt;
            state_nxt       = S_DONE;
          end
        end
      end

      S_DONE: begin
        window_done_nxt = 1'b1;
        state_nxt       = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Purpose : randomized scoreboard bench for spike_rate_encoder against an
//           arithmetic reference (slot k spikes iff floor(k*v/2^D) steps up).
// Latency : driver pushes per-edge expectations at negedge; monitor pops #1 after posedge.
// Backpr. : driver tracks acceptance timing itself; monitor never drives the DUT.
module tb_spike_rate_encoder;

  localparam int DATA_W   = 8;
  localparam int WIN_LOG2 = 8;
  localparam int W        = 1 << WIN_LOG2;

  logic                clk;
  logic                rst_n;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic                en;
  logic                spike;
  logic                busy;
  logic                window_done;
  logic [WIN_LOG2-1:0] spike_count;

  spike_rate_encoder #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .en          (en),
    .spike       (spike),
    .busy        (busy),
    .window_done (window_done),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  // Expected DUT outputs just after one rising edge.
  typedef struct packed {
    logic spk;
    logic done;
    logic bsy;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Reference: the accumulated phase k*v crosses a multiple of 2^DATA_W.
  function automatic logic model_spike(input int v, input int k);
    return ((k * v) >> DATA_W) != (((k - 1) * v) >> DATA_W);
  endfunction

  function automatic int model_count(input int v);
    return (v * W) >> DATA_W;
  endfunction

  // Monitor: one expectation per rising edge, compared #1 after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("spike", int'(spike), int'(e.spk));
        check("window_done", int'(window_done), int'(e.done));
        check("busy", int'(busy), int'(e.bsy));
        check("in_ready", int'(in_ready), int'(!e.bsy));
        if (e.done) begin
          check("count_queue_size", cnt_q.size(), 1);
          if (cnt_q.size() > 0) check("spike_count", int'(spike_count), cnt_q.pop_front());
        end
      end
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    en       = 1'($urandom_range(0, 1));
    exp_q.push_back('{spk: 1'b0, done: 1'b0, bsy: 1'b0});
  endtask

  // One full window. stall_slot>0 inserts stall_len disabled cycles before
  // that slot; junk keeps in_valid high with random data while busy;
  // rnd_en drops en randomly.
  task automatic run_window(input int v, input int stall_slot, input int stall_len,
                            input bit junk, input bit rnd_en);
    int k;
    int stalled;
    bit e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    en       = 1'($urandom_range(0, 1));
    exp_q.push_back('{spk: 1'b0, done: 1'b0, bsy: 1'b1});
    k = 1;
    stalled = 0;
    while (k <= W) begin
      @(negedge clk);
      in_valid = junk;
      in_data  = DATA_W'($urandom_range(0, 255));
      e = 1'b1;
      if (k == stall_slot && stalled < stall_len) begin
        e = 1'b0;
        stalled++;
      end else if (rnd_en && $urandom_range(0, 3) == 0) begin
        e = 1'b0;
      end
      en = e;
      if (e) begin
        exp_q.push_back('{spk: model_spike(v, k), done: 1'b0, bsy: 1'b1});
        k++;
      end else begin
        exp_q.push_back('{spk: 1'b0, done: 1'b0, bsy: 1'b1});
      end
    end
    // DONE cycle: en is ignored, window_done and the final count appear.
    @(negedge clk);
    in_valid = junk;
    in_data  = DATA_W'($urandom_range(0, 255));
    en       = 1'($urandom_range(0, 1));
    exp_q.push_back('{spk: 1'b0, done: 1'b1, bsy: 1'b0});
    cnt_q.push_back(model_count(v));
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    en       = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_spike", int'(spike), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_window_done", int'(window_done), 0);
    check("rst_spike_count", int'(spike_count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Fixed boundary windows
    run_window(0, 0, 0, 1'b0, 1'b0);
    idle_cycle();
    run_window(128, 0, 0, 1'b0, 1'b0);
    run_window(255, 0, 0, 1'b0, 1'b0);
    run_window(1, 0, 0, 1'b0, 1'b0);
    idle_cycle();
    run_window(64, 37, 10, 1'b0, 1'b0);
    idle_cycle();

    // in_valid held high with changing data while busy; back-to-back windows
    run_window(100, 0, 0, 1'b1, 1'b0);
    run_window(37, 0, 0, 1'b1, 1'b0);
    idle_cycle();

    // Randomized windows with random en stalls
    repeat (5) begin
      run_window($urandom_range(0, 255), 0, 0, 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Reset mid-window: leave a nonzero spike_count behind first
    run_window(255, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_W'(200);
    en       = 1'b1;
    exp_q.push_back('{spk: 1'b0, done: 1'b0, bsy: 1'b1});
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      en       = 1'b1;
      exp_q.push_back('{spk: model_spike(200, k), done: 1'b0, bsy: 1'b1});
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_spike", int'(spike), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_window_done", int'(window_done), 0);
    check("midrst_spike_count", int'(spike_count), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    run_window(200, 0, 0, 1'b0, 1'b0);
    idle_cycle();

    repeat (3) @(negedge clk);
    check("queue_drain", exp_q.size() + cnt_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
